// File: rtl/sd_cmd_sequencer_pkg.sv
// rtl/sd_cmd_sequencer_pkg.sv - SD CMD line sequencer states, frame widths and CRC7 polynomial
package sd_cmd_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_WAIT = 3'd2,
    ST_RECV = 3'd3,
    ST_GAP  = 3'd4
  } sd_cmd_state_t;

  localparam int CMD_BITS          = 48;
  localparam int CMD_HDR_BITS      = 40;   // start, transmit, index, argument
  localparam int RSP_SHORT_BITS    = 48;
  localparam int RSP_LONG_BITS     = 136;
  localparam int RSP_LONG_HDR_BITS = 7;    // R2 transmit + reserved bits after the start bit

  // x^7 + x^3 + 1, implicit x^7 term
  localparam logic [6:0] CRC7_POLY = 7'h09;

endpackage

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - serial CRC7 generator with clear, enable and bit input
module sd_crc7
  import sd_cmd_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic fb;

  assign fb = din ^ crc[6];

  // One bit per enabled cycle, MSB first; clear takes priority over enable
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// rtl/sd_cmd_sequencer.sv - SD CMD line sequencer (send, response hunt, receive, NCC gap); optional SD_CMD_RSP_CRC_CHECK_EN
module sd_cmd_sequencer
  import sd_cmd_sequencer_pkg::*;
#(
  parameter int RSP_TIMEOUT = 64,
  parameter int NCC_CYCLES  = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_cmd_stb,
  input  logic [5:0]   i_cmd_index,
  input  logic [31:0]  i_cmd_arg,
  input  logic         i_rsp_en,
  input  logic         i_rsp_long,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_timeout,
  output logic         o_crc_err,
  output logic [127:0] o_rsp,
  output logic         o_sd_cmd_dir,
  output logic         o_sd_cmd_out,
  input  logic         i_sd_cmd_in
);

  sd_cmd_state_t state, state_nxt;

  logic [5:0]   bit_cnt;
  logic [7:0]   rsp_cnt;
  logic [39:0]  tx_shift;
  logic [126:0] rx_shift;
  logic [6:0]   tx_crc;
  logic [2:0]   crc_idx;
  logic [7:0]   recv_last_cnt;
  logic         rsp_en_q;
  logic         rsp_long_q;
  logic         accept;
  logic         send_last;
  logic         wait_expire;
  logic         recv_last;
  logic         gap_last;
  logic         tx_crc_en;

  assign accept        = (state == ST_IDLE) && i_cmd_stb;
  assign send_last     = bit_cnt == 6'(CMD_BITS - 1);
  assign wait_expire   = rsp_cnt == 8'(RSP_TIMEOUT - 1);
  assign recv_last_cnt = rsp_long_q ? 8'(RSP_LONG_BITS - 2) : 8'(RSP_SHORT_BITS - 2);
  assign recv_last     = rsp_cnt == recv_last_cnt;
  assign gap_last      = bit_cnt == 6'(NCC_CYCLES - 1);
  // CRC bits go out at bit_cnt 40..46, whose low three bits run 0..6
  assign crc_idx       = 3'd6 - bit_cnt[2:0];
  assign tx_crc_en     = (state == ST_SEND) && (bit_cnt < 6'(CMD_HDR_BITS));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and line/handshake outputs
  always_comb begin
    state_nxt    = state;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    o_sd_cmd_dir = 1'b1;
    o_sd_cmd_out = 1'b1;
    case (state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_cmd_stb) state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (bit_cnt < 6'(CMD_HDR_BITS)) begin
          o_sd_cmd_out = tx_shift[39];
        end else if (!send_last) begin
          o_sd_cmd_out = tx_crc[crc_idx];
        end
        if (send_last) state_nxt = rsp_en_q ? ST_WAIT : ST_GAP;
      end
      ST_WAIT: begin
        o_sd_cmd_dir = 1'b0;
        if (!i_sd_cmd_in) begin
          state_nxt = ST_RECV;
        end else if (wait_expire) begin
          state_nxt = ST_GAP;
        end
      end
      ST_RECV: begin
        o_sd_cmd_dir = 1'b0;
        if (recv_last) state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (gap_last) begin
          o_done    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bit counter paces SEND and GAP; restarts on every state change, saturates otherwise
  always_ff @(posedge clk) begin
    if (rst || (state_nxt != state)) begin
      bit_cnt <= '0;
    end else if (bit_cnt != '1) begin
      bit_cnt <= bit_cnt + 6'd1;
    end
  end

  // Response counter paces WAIT and RECV; restarts on every state change, saturates otherwise
  always_ff @(posedge clk) begin
    if (rst || (state_nxt != state)) begin
      rsp_cnt <= '0;
    end else if (rsp_cnt != '1) begin
      rsp_cnt <= rsp_cnt + 8'd1;
    end
  end

  // Latch the command on acceptance, then shift the header out MSB first
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift   <= '0;
      rsp_en_q   <= 1'b0;
      rsp_long_q <= 1'b0;
    end else if (accept) begin
      tx_shift   <= {2'b01, i_cmd_index, i_cmd_arg};
      rsp_en_q   <= i_rsp_en;
      rsp_long_q <= i_rsp_long;
    end else if (state == ST_SEND) begin
      tx_shift   <= {tx_shift[38:0], 1'b0};
    end
  end

  sd_crc7 u_tx_crc (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (tx_crc_en),
    .din (tx_shift[39]),
    .crc (tx_crc)
  );

  // Shift the response in; R2 header bits fall off the top, o_rsp is loaded only on the end bit
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_shift <= '0;
      o_rsp    <= '0;
    end else if (accept) begin
      rx_shift <= '0;
    end else if (state == ST_RECV) begin
      rx_shift <= {rx_shift[125:0], i_sd_cmd_in};
      if (recv_last) o_rsp <= {rx_shift, i_sd_cmd_in};
    end
  end

  // Sticky timeout: set when the response window closes without a start bit
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      o_timeout <= 1'b0;
    end else if ((state == ST_WAIT) && i_sd_cmd_in && wait_expire) begin
      o_timeout <= 1'b1;
    end
  end

`ifdef SD_CMD_RSP_CRC_CHECK_EN
  logic [6:0] rx_crc;
  logic       rx_crc_en;
  logic       crc_bad;
  logic       crc_err_q;

  // The start bit is zero and leaves a zero-initialised CRC unchanged, so it needs no slot here
  assign rx_crc_en = (state == ST_RECV) && !recv_last &&
                     (!rsp_long_q || (rsp_cnt >= 8'(RSP_LONG_HDR_BITS)));

  sd_crc7 u_rx_crc (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (rx_crc_en),
    .din (i_sd_cmd_in),
    .crc (rx_crc)
  );

  // Running CRC over data plus received CRC field leaves zero on a clean frame; flag shows with o_done
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      crc_bad   <= 1'b0;
      crc_err_q <= 1'b0;
    end else begin
      if ((state == ST_RECV) && recv_last) crc_bad <= (rx_crc != 7'd0);
      if (o_done && crc_bad) crc_err_q <= 1'b1;
    end
  end

  assign o_crc_err = crc_err_q | (o_done & crc_bad);
`else
  assign o_crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// tb/tb_sd_cmd_sequencer.sv - self-checking bench for sd_cmd_sequencer (vector table, corner sequences, random)
module tb_sd_cmd_sequencer;

  localparam int NCC    = 8;
  localparam int RSP_TO = 64;
`ifdef SD_CMD_RSP_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         i_cmd_stb;
  logic [5:0]   i_cmd_index;
  logic [31:0]  i_cmd_arg;
  logic         i_rsp_en;
  logic         i_rsp_long;
  logic         o_busy;
  logic         o_done;
  logic         o_timeout;
  logic         o_crc_err;
  logic [127:0] o_rsp;
  logic         o_sd_cmd_dir;
  logic         o_sd_cmd_out;
  logic         i_sd_cmd_in;

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_rsp_q;
  logic         prev_to;
  logic         prev_crc;

  typedef struct {
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic         rsp_en;
    logic         rsp_long;
    int           delay;
    logic [135:0] rsp_frame;
    int           extra_stb;
    logic [47:0]  exp_frame;
    int           exp_done;
    logic         exp_to;
    logic         exp_crc;
    logic [127:0] exp_rsp;
    logic         upd_rsp;
  } vec_t;

  vec_t tbl [9];

  sd_cmd_sequencer #(.RSP_TIMEOUT(RSP_TO), .NCC_CYCLES(NCC)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_cmd_stb    (i_cmd_stb),
    .i_cmd_index  (i_cmd_index),
    .i_cmd_arg    (i_cmd_arg),
    .i_rsp_en     (i_rsp_en),
    .i_rsp_long   (i_rsp_long),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_timeout    (o_timeout),
    .o_crc_err    (o_crc_err),
    .o_rsp        (o_rsp),
    .o_sd_cmd_dir (o_sd_cmd_dir),
    .o_sd_cmd_out (o_sd_cmd_out),
    .i_sd_cmd_in  (i_sd_cmd_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Remainder of data(x) * x^7 divided by x^7+x^3+1, by long division
  function automatic logic [6:0] crc7(input logic [127:0] data, input int n);
    logic [134:0] r;
    r = {data, 7'b0};
    for (int i = n + 6; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [135:0] make_short(input logic [5:0] idx, input logic [31:0] arg,
                                              input bit corrupt, input int flip);
    logic [135:0] f;
    logic [39:0]  hdr;
    hdr = {2'b00, idx, arg};
    f = {88'b0, hdr, crc7({88'b0, hdr}, 40), 1'b1};
    if (corrupt) f[flip] = ~f[flip];
    return f;
  endfunction

  function automatic logic [135:0] make_long(input logic [119:0] body, input bit corrupt, input int flip);
    logic [135:0] f;
    f = {8'h3F, body, crc7({8'b0, body}, 120), 1'b1};
    if (corrupt) f[flip] = ~f[flip];
    return f;
  endfunction

  // Transaction-level expectations from the frame rules and the cycle budget of each phase
  function automatic vec_t mk(input logic [5:0] idx, input logic [31:0] arg, input logic en,
                              input logic lng, input int delay, input logic [135:0] fr, input int extra);
    vec_t v;
    int len;
    logic [39:0] hdr;
    v.idx = idx; v.arg = arg; v.rsp_en = en; v.rsp_long = lng;
    v.delay = delay; v.rsp_frame = fr; v.extra_stb = extra;
    hdr = {2'b01, idx, arg};
    v.exp_frame = {hdr, crc7({88'b0, hdr}, 40), 1'b1};
    len = lng ? 136 : 48;
    v.exp_to = 1'b0; v.exp_crc = 1'b0; v.upd_rsp = 1'b0; v.exp_rsp = '0;
    if (!en) begin
      v.exp_done = 48 + NCC;
    end else if (delay >= RSP_TO) begin
      v.exp_done = 48 + RSP_TO + NCC;
      v.exp_to = 1'b1;
    end else begin
      v.exp_done = 48 + delay + len + NCC;
      v.upd_rsp = 1'b1;
      if (lng) begin
        v.exp_rsp = fr[127:0];
        v.exp_crc = CRC_EN && (crc7({8'b0, fr[127:8]}, 120) != fr[7:1]);
      end else begin
        v.exp_rsp = {81'b0, fr[46:0]};
        v.exp_crc = CRC_EN && (crc7({88'b0, fr[47:8]}, 40) != fr[7:1]);
      end
    end
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    logic [47:0] cap;
    int line_bad, busy_bad, done_at, len;
    cap = '0; line_bad = 0; busy_bad = 0; done_at = 0;
    len = v.rsp_long ? 136 : 48;
    @(negedge clk);
    check({tag, ":sticky_to"}, 128'(o_timeout), 128'(prev_to));
    check({tag, ":sticky_crc"}, 128'(o_crc_err), 128'(prev_crc));
    i_cmd_index = v.idx; i_cmd_arg = v.arg; i_rsp_en = v.rsp_en; i_rsp_long = v.rsp_long;
    i_cmd_stb = 1'b1;
    @(negedge clk);
    i_cmd_stb = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      if (k == 1) begin
        check({tag, ":to_cleared"}, 128'(o_timeout), 128'(0));
        check({tag, ":crc_cleared"}, 128'(o_crc_err), 128'(0));
      end
      if (k <= 48) cap[48 - k] = o_sd_cmd_out;
      if (k <= v.exp_done) begin
        if (o_busy !== 1'b1) busy_bad++;
        if (k <= 48 || k > v.exp_done - NCC) begin
          if (o_sd_cmd_dir !== 1'b1) line_bad++;
          if (k > 48 && o_sd_cmd_out !== 1'b1) line_bad++;
        end else if (o_sd_cmd_dir !== 1'b0) begin
          line_bad++;
        end
      end
      if (k == 48) check({tag, ":rsp_hold"}, o_rsp, exp_rsp_q);
      if (k == v.exp_done - 1) check({tag, ":crc_early"}, 128'(o_crc_err), 128'(0));
      if (o_done === 1'b1) begin
        done_at = k;
        check({tag, ":timeout"}, 128'(o_timeout), 128'(v.exp_to));
        check({tag, ":crc_err"}, 128'(o_crc_err), 128'(v.exp_crc));
        check({tag, ":rsp"}, o_rsp, v.upd_rsp ? v.exp_rsp : exp_rsp_q);
        break;
      end
      if (k == v.extra_stb) begin
        i_cmd_stb = 1'b1; i_cmd_index = 6'h3F;
      end else if (k == v.extra_stb + 1) begin
        i_cmd_stb = 1'b0; i_cmd_index = v.idx;
      end
      if (v.rsp_en && k >= 49 + v.delay && k - 49 - v.delay < len)
        i_sd_cmd_in = v.rsp_frame[len - 1 - (k - 49 - v.delay)];
      else
        i_sd_cmd_in = 1'b1;
      @(negedge clk);
    end
    i_cmd_stb = 1'b0;
    i_sd_cmd_in = 1'b1;
    check({tag, ":frame"}, 128'(cap), 128'(v.exp_frame));
    check({tag, ":line_errs"}, 128'(line_bad), 128'(0));
    check({tag, ":busy_errs"}, 128'(busy_bad), 128'(0));
    check({tag, ":done_cycle"}, 128'(done_at), 128'(v.exp_done));
    if (done_at != 0) begin
      @(negedge clk);
      check({tag, ":busy_after"}, 128'(o_busy), 128'(0));
      check({tag, ":done_pulse"}, 128'(o_done), 128'(0));
    end
    if (v.upd_rsp) exp_rsp_q = v.exp_rsp;
    prev_to = v.exp_to;
    prev_crc = v.exp_crc;
  endtask

  task automatic reset_mid_send();
    int idle_bad;
    idle_bad = 0;
    @(negedge clk);
    i_cmd_index = 6'd17; i_cmd_arg = 32'h0000_0200; i_rsp_en = 1'b1; i_rsp_long = 1'b0;
    i_cmd_stb = 1'b1;
    @(negedge clk);
    i_cmd_stb = 1'b0;
    repeat (20) @(negedge clk);
    check("mid:busy", 128'(o_busy), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid:dir", 128'(o_sd_cmd_dir), 128'(1));
    check("mid:out", 128'(o_sd_cmd_out), 128'(1));
    check("mid:busy_low", 128'(o_busy), 128'(0));
    check("mid:rsp_zero", o_rsp, 128'(0));
    repeat (6) begin
      @(negedge clk);
      if (o_sd_cmd_out !== 1'b1 || o_sd_cmd_dir !== 1'b1 || o_busy !== 1'b0) idle_bad++;
    end
    check("mid:stays_idle", 128'(idle_bad), 128'(0));
    exp_rsp_q = '0; prev_to = 1'b0; prev_crc = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [5:0]   r_idx;
    logic [31:0]  r_arg;
    logic         r_en, r_lng;
    int           r_dly;
    bit           r_bad;
    logic [135:0] r_fr;

    rst = 1'b1; i_cmd_stb = 1'b0; i_cmd_index = '0; i_cmd_arg = '0;
    i_rsp_en = 1'b0; i_rsp_long = 1'b0; i_sd_cmd_in = 1'b1;
    exp_rsp_q = '0; prev_to = 1'b0; prev_crc = 1'b0;
    repeat (3) @(negedge clk);
    check("reset:busy", 128'(o_busy), 128'(0));
    check("reset:done", 128'(o_done), 128'(0));
    check("reset:timeout", 128'(o_timeout), 128'(0));
    check("reset:crc_err", 128'(o_crc_err), 128'(0));
    check("reset:rsp", o_rsp, 128'(0));
    check("reset:dir", 128'(o_sd_cmd_dir), 128'(1));
    check("reset:out", 128'(o_sd_cmd_out), 128'(1));
    rst = 1'b0;

    tbl[0] = mk(6'd0, 32'h0, 1'b0, 1'b0, 0, '0, 0);
    tbl[0].exp_frame = 48'h400000000095; tbl[0].exp_done = 56;
    tbl[1] = mk(6'd8, 32'h1AA, 1'b1, 1'b0, 5, 136'h08000001AA13, 0);
    tbl[1].exp_frame = 48'h48000001AA87; tbl[1].exp_done = 109;
    tbl[1].exp_rsp = 128'h08000001AA13; tbl[1].exp_crc = 1'b0; tbl[1].exp_to = 1'b0;
    tbl[2] = mk(6'd8, 32'h1AA, 1'b1, 1'b0, 5, 136'h08000001AA15, 0);
    tbl[2].exp_frame = 48'h48000001AA87; tbl[2].exp_done = 109;
    tbl[2].exp_rsp = 128'h08000001AA15; tbl[2].exp_crc = CRC_EN;
    tbl[3] = mk(6'd2, 32'h0, 1'b1, 1'b1, 1000, '0, 0);
    tbl[3].exp_frame = 48'h42000000004D; tbl[3].exp_done = 120;
    tbl[3].exp_to = 1'b1; tbl[3].upd_rsp = 1'b0;
    tbl[4] = mk(6'd2, 32'h0, 1'b1, 1'b1, 2,
                make_long(120'h035344_5331_3647_8012_3456_789A_B0A5, 1'b0, 0), 0);
    tbl[5] = mk(6'd55, 32'hDEADBEEF, 1'b1, 1'b0, 63, make_short(6'd55, 32'h12345678, 1'b0, 0), 0);
    tbl[6] = mk(6'd13, 32'h0, 1'b1, 1'b0, 64, make_short(6'd13, 32'h0, 1'b0, 0), 0);
    tbl[7] = mk(6'd9, 32'hA5A5_0000, 1'b1, 1'b1, 0,
                make_long(120'hFEDCBA9876543210_0F1E2D3C4B5A69, 1'b1, 100), 0);
    tbl[8] = mk(6'd0, 32'h0, 1'b0, 1'b0, 0, '0, 10);
    tbl[8].exp_frame = 48'h400000000095; tbl[8].exp_done = 56;

    for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    reset_mid_send();
    run_vec(tbl[1], "after_reset");

    for (int i = 0; i < 12; i++) begin
      r_idx = 6'($urandom_range(0, 63));
      r_arg = $urandom;
      r_en  = ($urandom_range(0, 3) != 0);
      r_lng = 1'($urandom_range(0, 1));
      r_dly = ($urandom_range(0, 5) == 0) ? 64 + int'($urandom_range(0, 4)) : int'($urandom_range(0, 63));
      r_bad = ($urandom_range(0, 3) == 0);
      if (r_lng)
        r_fr = make_long({$urandom, $urandom, $urandom, 24'($urandom)}, r_bad, int'($urandom_range(8, 127)));
      else
        r_fr = make_short(6'($urandom), $urandom, r_bad, int'($urandom_range(8, 46)));
      run_vec(mk(r_idx, r_arg, r_en, r_lng, r_dly, r_fr, 0), $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
